// File: rtl/tl45_wb_scratchpad.sv
// Pipelined Wishbone scratchpad responder: one transaction at a time, byte-lane
// writes, ack (or ack+err outside the address window) LATENCY cycles after acceptance.
module tl45_wb_scratchpad #(
  parameter logic [29:0] BASE_ADDR = 30'h0000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          hit;
  logic [AW-1:0] idx;

  // Handshake: a request is taken on any edge where stall is low and cyc&stb are high;
  // ack is a one-cycle pulse, suppressed if the master has dropped cyc.
  assign accept = (state_q == IDLE) && i_wb_cyc && i_wb_stb;
  assign hit    = (i_wb_addr[29:AW] == BASE_ADDR[29:AW]);
  assign idx    = i_wb_addr[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (!i_wb_cyc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        hit_q   <= hit;
        rdata_q <= (hit && !i_wb_we) ? mem[idx] : '0;
      end
    end
  end

  // RAM is not reset; a write is committed at the acceptance edge and never undone.
  always_ff @(posedge i_clk) begin
    if (!i_reset && accept && hit && i_wb_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b]) mem[idx][8*b +: 8] <= i_wb_data[8*b +: 8];
      end
    end
  end

  assign o_wb_stall  = (state_q != IDLE);
  assign o_wb_ack    = (state_q == RESP) && i_wb_cyc;
  assign o_wb_err    = o_wb_ack && !hit_q;
  assign o_wb_data   = o_wb_ack ? rdata_q : '0;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_tl45_wb_scratchpad.sv
// Bench for tl45_wb_scratchpad: one instance at LATENCY=1 and one at LATENCY=4,
// expected responses queued at drive time and compared on each ack.
module tb_tl45_wb_scratchpad;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc1, cyc4, stb, we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;

  logic        ack1, stall1, err1, ack4, stall4, err4;
  logic [31:0] rdata1, rdata4;
  logic [1:0]  dbg1, dbg4;

  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  tl45_wb_scratchpad #(.BASE_ADDR(30'h0), .DEPTH(1024), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc1), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_ack(ack1), .o_wb_stall(stall1), .o_wb_err(err1), .o_wb_data(rdata1),
    .o_dbg_state(dbg1)
  );

  tl45_wb_scratchpad #(.BASE_ADDR(30'h0), .DEPTH(1024), .LATENCY(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc4), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_ack(ack4), .o_wb_stall(stall4), .o_wb_err(err4), .o_wb_data(rdata4),
    .o_dbg_state(dbg4)
  );

  task automatic sample(input int which, output logic a, output logic st,
                        output logic e, output logic [31:0] d);
    if (which == 1) begin a = ack1; st = stall1; e = err1; d = rdata1; end
    else            begin a = ack4; st = stall4; e = err4; d = rdata4; end
  endtask

  task automatic set_cyc(input int which, input logic v);
    if (which == 1) cyc1 = v; else cyc4 = v;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // One complete transaction; expects ack exactly LATENCY cycles after acceptance.
  task automatic xact(input int which, input logic w, input logic [29:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [32:0] exp, input string name);
    int          lat;
    int          cyc_n;
    logic        a_s, st_s, e_s;
    logic [31:0] d_s;
    logic [32:0] e_v;
    lat = (which == 1) ? 1 : 4;
    exp_q.push_back(exp);
    sample(which, a_s, st_s, e_s, d_s);
    n_checks++;
    if (st_s !== 1'b0) begin
      n_fail++; $display("FAIL %s pre_stall: got %b want 0", name, st_s);
    end
    set_cyc(which, 1'b1);
    stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    next_cycle();
    stb = 1'b0; we = 1'($urandom_range(0, 1)); addr = 30'($urandom);
    wdata = $urandom; sel = 4'($urandom_range(0, 15));
    cyc_n = 1;
    sample(which, a_s, st_s, e_s, d_s);
    while (a_s !== 1'b1 && cyc_n < 20) begin
      next_cycle(); cyc_n++;
      sample(which, a_s, st_s, e_s, d_s);
    end
    n_checks++;
    if (a_s !== 1'b1) begin
      n_fail++; $display("FAIL %s ack_timeout: got no ack want ack after %0d", name, lat);
    end else begin
      if (cyc_n != lat) begin
        n_fail++; $display("FAIL %s latency: got %0d want %0d", name, cyc_n, lat);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL %s scoreboard: got ack want no ack (queue empty)", name);
      end else begin
        e_v = exp_q.pop_front();
        if ({e_s, d_s} !== e_v) begin
          n_fail++; $display("FAIL %s resp: got err=%b data=%h want err=%b data=%h",
                             name, e_s, d_s, e_v[32], e_v[31:0]);
        end
      end
      n_checks++;
      if (st_s !== 1'b1) begin
        n_fail++; $display("FAIL %s ack_stall: got %b want 1", name, st_s);
      end
    end
    next_cycle();
    sample(which, a_s, st_s, e_s, d_s);
    n_checks++;
    if (st_s !== 1'b0 || a_s !== 1'b0) begin
      n_fail++; $display("FAIL %s post: got stall=%b ack=%b want 0 0", name, st_s, a_s);
    end
    set_cyc(which, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle(); next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      n_checks++;
      if ({ack1, stall1, err1, rdata1} !== 35'd0 || {ack4, stall4, err4, rdata4} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_idle: got l1 %b%b%b %h l4 %b%b%b %h want all 0",
                 ack1, stall1, err1, rdata1, ack4, stall4, err4, rdata4);
      end
    end
  endtask

  task automatic test_write_read();
    xact(1, 1'b1, 30'd5, 32'hDEADBEEF, 4'hF, {1'b0, 32'h0}, "wr5");
    xact(1, 1'b0, 30'd5, 32'h0, 4'h0, {1'b0, 32'hDEADBEEF}, "rd5");
  endtask

  task automatic test_byte_lanes();
    xact(1, 1'b1, 30'd7, 32'h11223344, 4'hF, {1'b0, 32'h0}, "bl_wr_full");
    xact(1, 1'b1, 30'd7, 32'hAABBCCDD, 4'b0101, {1'b0, 32'h0}, "bl_wr_part");
    xact(1, 1'b1, 30'd7, 32'h99999999, 4'b0000, {1'b0, 32'h0}, "bl_wr_none");
    xact(1, 1'b0, 30'd7, 32'h0, 4'b0001, {1'b0, 32'h11BB33DD}, "bl_rd");
  endtask

  task automatic test_out_of_window();
    xact(1, 1'b1, 30'd0, 32'h12345678, 4'hF, {1'b0, 32'h0}, "oow_wr0");
    xact(1, 1'b1, 30'h400, 32'hFFFFFFFF, 4'hF, {1'b1, 32'h0}, "oow_wr");
    xact(1, 1'b0, 30'h400, 32'h0, 4'hF, {1'b1, 32'h0}, "oow_rd");
    xact(1, 1'b0, 30'd0, 32'h0, 4'hF, {1'b0, 32'h12345678}, "oow_rd0");
  endtask

  // Read at edge N, second read held from the ack cycle, accepted at N+5.
  task automatic test_back_to_back();
    logic        exp_ack, exp_st;
    logic [32:0] e_v;
    xact(4, 1'b1, 30'd9, 32'h0BADF00D, 4'hF, {1'b0, 32'h0}, "b2b_wr9");
    xact(4, 1'b1, 30'd10, 32'h600DCAFE, 4'hF, {1'b0, 32'h0}, "b2b_wr10");
    exp_q.push_back({1'b0, 32'h0BADF00D});
    cyc4 = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'd9; sel = 4'hF;
    for (int t = 0; t <= 9; t++) begin
      next_cycle();
      if (t == 0) stb = 1'b0;
      exp_ack = (t == 3) || (t == 8);
      exp_st  = (t <= 3) || (t >= 5 && t <= 8);
      n_checks++;
      if (ack4 !== exp_ack || stall4 !== exp_st) begin
        n_fail++; $display("FAIL b2b_t%0d: got ack=%b stall=%b want ack=%b stall=%b",
                           t, ack4, stall4, exp_ack, exp_st);
      end
      if (ack4 === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_sb_t%0d: got ack want no ack (queue empty)", t);
        end else begin
          e_v = exp_q.pop_front();
          if ({err4, rdata4} !== e_v) begin
            n_fail++; $display("FAIL b2b_data_t%0d: got %b %h want %b %h",
                               t, err4, rdata4, e_v[32], e_v[31:0]);
          end
        end
      end
      if (t == 3) begin
        exp_q.push_back({1'b0, 32'h600DCAFE});
        stb = 1'b1; we = 1'b0; addr = 30'd10; sel = 4'h0;
      end
      if (t == 5) stb = 1'b0;
    end
    cyc4 = 1'b0;
  endtask

  task automatic abort_one(input logic w, input logic [29:0] a, input logic [31:0] d,
                           input string name);
    cyc4 = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = 4'hF;
    for (int t = 0; t <= 6; t++) begin
      next_cycle();
      if (t == 0) stb = 1'b0;
      if (t == 2) cyc4 = 1'b0;
      n_checks++;
      if (ack4 !== 1'b0 || err4 !== 1'b0) begin
        n_fail++; $display("FAIL %s ack_t%0d: got ack=%b err=%b want 0 0", name, t, ack4, err4);
      end
      if (t == 3) begin
        n_checks++;
        if (stall4 !== 1'b0) begin
          n_fail++; $display("FAIL %s idle: got stall=%b want 0", name, stall4);
        end
      end
    end
  endtask

  task automatic test_abort();
    abort_one(1'b0, 30'd9, 32'h0, "abort_rd");
    abort_one(1'b1, 30'd12, 32'hCAFEF00D, "abort_wr");
    xact(4, 1'b0, 30'd12, 32'h0, 4'hF, {1'b0, 32'hCAFEF00D}, "abort_rd12");
  endtask

  initial begin
    rst = 1'b1; cyc1 = 1'b0; cyc4 = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_window();
    test_back_to_back();
    test_abort();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
